// File: rtl/pll_reconfig_pkg.sv
// Shared constants and types for the PLL reconfiguration sequencer:
// scan-chain counter addresses, the sequencer state encoding and the
// parameter word presented to the reconfig megafunction.
package pll_reconfig_pkg;

  // Number of scan-chain parameter writes per reconfiguration.
  localparam int NUM_WRITES = 8;

  // Counter-type addresses.
  localparam logic [3:0] CT_N  = 4'b0000;
  localparam logic [3:0] CT_M  = 4'b0001;
  localparam logic [3:0] CT_C0 = 4'b0100;

  // Counter-param addresses.
  localparam logic [2:0] CP_COUNT    = 3'b111;
  localparam logic [2:0] CP_HIGH     = 3'b000;
  localparam logic [2:0] CP_LOW      = 3'b001;
  localparam logic [2:0] CP_BYPASS   = 3'b100;
  localparam logic [2:0] CP_ODD_EVEN = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WRITE,
    ST_WAIT_WR,
    ST_RECONFIG,
    ST_WAIT_RC,
    ST_WAIT_LOCK,
    ST_DONE
  } state_t;

  // One parameter write: address pair plus 9-bit data.
  typedef struct packed {
    logic [3:0] ctype;
    logic [2:0] cparam;
    logic [8:0] data;
  } param_word_t;

endpackage

// File: rtl/pll_reconfig_sequencer_if.sv
// Request and megafunction-side signals of the PLL reconfiguration
// sequencer. The slave modport is the sequencer's view; master is the
// environment (requester plus PLL_CONFIG megafunction).
interface pll_reconfig_sequencer_if;

  // Request side
  logic [7:0] m;
  logic [7:0] n;
  logic [7:0] c0;
  logic       strobe;
  logic       busy;
  logic       done;
  logic       error;

  // Megafunction side
  logic [3:0] counter_type;
  logic [2:0] counter_param;
  logic [8:0] data_in;
  logic       write_param;
  logic       reconfig;
  logic       reconfig_busy;
  logic       pll_lock;

  modport master (
    output m, n, c0, strobe, reconfig_busy, pll_lock,
    input  busy, done, error, counter_type, counter_param, data_in,
           write_param, reconfig
  );

  modport slave (
    input  m, n, c0, strobe, reconfig_busy, pll_lock,
    output busy, done, error, counter_type, counter_param, data_in,
           write_param, reconfig
  );

endinterface

// File: rtl/pll_param_encode.sv
// Maps a write index k and the latched divider set to the scan-chain
// address and data for that write. Purely combinational.
module pll_param_encode
  import pll_reconfig_pkg::*;
(
  input  logic [2:0]  k,
  input  logic [7:0]  m,
  input  logic [7:0]  n,
  input  logic [7:0]  c0,
  output param_word_t word
);

  // Select the table entry for index k.
  always_comb begin
    logic [8:0] c0_plus;
    // NOTE: every variable gets a value before the case so no path leaves it unassigned (no latch).
    word    = '0;
    c0_plus = {1'b0, c0} + 9'd1;   // 9-bit so c0=255 rounds up to 128
    case (k)
      3'd0: word = '{ctype: CT_N,  cparam: CP_COUNT,  data: {1'b0, n}};
      3'd1: word = '{ctype: CT_N,  cparam: CP_BYPASS, data: {8'd0, n == 8'd1}};
      3'd2: word = '{ctype: CT_M,  cparam: CP_COUNT,  data: {1'b0, m}};
      3'd3: word = '{ctype: CT_M,  cparam: CP_BYPASS, data: {8'd0, m == 8'd1}};
      3'd4: word = '{ctype: CT_C0, cparam: CP_HIGH,   data: c0_plus >> 1};
      3'd5: word = '{ctype: CT_C0, cparam: CP_LOW,
                     data: (c0 == 8'd1) ? 9'd1 : {2'b00, c0[7:1]}};
      3'd6: word = '{ctype: CT_C0, cparam: CP_BYPASS, data: {8'd0, c0 == 8'd1}};
      3'd7: word = '{ctype: CT_C0, cparam: CP_ODD_EVEN,
                     data: (c0 > 8'd1) ? {8'd0, c0[0]} : 9'd0};
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/pll_reconfig_sequencer.sv
// Busy-handshaked sequencer in front of PLL_CONFIG: latches an M/N/C0
// request, streams the eight scan-chain writes, pulses reconfig, waits
// for a stable lock (or times out) and ends each request with done.
module pll_reconfig_sequencer
  import pll_reconfig_pkg::*;
#(
  parameter int LOCK_STABLE  = 16,
  parameter int LOCK_TIMEOUT = 65535
) (
  input logic                     clk,
  input logic                     reset,
  pll_reconfig_sequencer_if.slave bus
);

  localparam int                  STABLE_W     = $clog2(LOCK_STABLE + 1);
  localparam logic [STABLE_W-1:0] STABLE_LAST  = STABLE_W'(LOCK_STABLE - 1);
  localparam logic [15:0]         TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [2:0]          LAST_K       = 3'(NUM_WRITES - 1);

  state_t              state, state_next;
  logic [2:0]          k, k_next;
  logic                err_q, err_next;
  logic                guard_q;
  logic [7:0]          m_q, n_q, c0_q;
  logic [STABLE_W-1:0] stable_cnt;
  logic [15:0]         timeout_cnt;
  param_word_t         word_next, word_q;

  // Table lookup for the write about to be issued (indexed by k_next).
  pll_param_encode u_encode (
    .k    (k_next),
    .m    (m_q),
    .n    (n_q),
    .c0   (c0_q),
    .word (word_next)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state, write index and error-flag decisions.
  always_comb begin
    state_next = state;
    k_next     = k;
    err_next   = err_q;
    case (state)
      ST_IDLE:  if (bus.strobe) state_next = ST_CHECK;
      ST_CHECK: begin
        if (m_q == 8'd0 || n_q == 8'd0 || c0_q == 8'd0) begin
          err_next   = 1'b1;
          state_next = ST_DONE;
        end else begin
          err_next   = 1'b0;
          k_next     = 3'd0;
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: state_next = ST_WAIT_WR;
      ST_WAIT_WR: begin
        // The first cycle after a write is a guard: busy may not have risen yet.
        if (!guard_q && !bus.reconfig_busy) begin
          if (k == LAST_K) begin
            state_next = ST_RECONFIG;
          end else begin
            k_next     = k + 3'd1;
            state_next = ST_WRITE;
          end
        end
      end
      ST_RECONFIG: state_next = ST_WAIT_RC;
      ST_WAIT_RC:  if (!guard_q && !bus.reconfig_busy) state_next = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        // Lock is checked first so it wins a same-cycle timeout.
        if (bus.pll_lock && stable_cnt == STABLE_LAST) begin
          err_next   = 1'b0;
          state_next = ST_DONE;
        end else if (timeout_cnt == TIMEOUT_LAST) begin
          err_next   = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Request latch, write index, guard flag and the registered parameter word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k       <= 3'd0;
      err_q   <= 1'b0;
      guard_q <= 1'b0;
      m_q     <= 8'd0;
      n_q     <= 8'd0;
      c0_q    <= 8'd0;
      word_q  <= '0;
    end else begin
      k       <= k_next;
      err_q   <= err_next;
      guard_q <= (state == ST_WRITE) || (state == ST_RECONFIG);
      if (state == ST_IDLE && bus.strobe) begin
        m_q  <= bus.m;
        n_q  <= bus.n;
        c0_q <= bus.c0;
      end
      // Load on entry to WRITE so address/data hold through the whole wait.
      if (state_next == ST_WRITE) word_q <= word_next;
    end
  end

  // Lock-stable and timeout counters, both cleared outside WAIT_LOCK.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_cnt  <= '0;
      timeout_cnt <= 16'd0;
    end else if (state != ST_WAIT_LOCK) begin
      stable_cnt  <= '0;
      timeout_cnt <= 16'd0;
    end else begin
      stable_cnt  <= bus.pll_lock ? stable_cnt + STABLE_W'(1) : '0;
      timeout_cnt <= timeout_cnt + 16'd1;
    end
  end

  // busy covers the working states; it is already low on the done cycle.
  assign bus.busy          = (state != ST_IDLE) && (state != ST_DONE);
  assign bus.write_param   = (state == ST_WRITE);
  assign bus.reconfig      = (state == ST_RECONFIG);
  assign bus.done          = (state == ST_DONE);
  assign bus.error         = (state == ST_DONE) && err_q;
  assign bus.counter_type  = word_q.ctype;
  assign bus.counter_param = word_q.cparam;
  assign bus.data_in       = word_q.data;

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// Scoreboard bench for pll_reconfig_sequencer. Each request pushes its
// expected write/reconfig/done events (with cycle stamps where timing is
// predictable) into a queue; a negedge monitor pops and compares them.
module tb_pll_reconfig_sequencer;

  localparam int LOCK_STABLE  = 16;
  localparam int LOCK_TIMEOUT = 100;

  typedef enum int {EV_WRITE, EV_RECONFIG, EV_DONE} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       ctype;
    int       cparam;
    int       data;
    int       err;
    int       cyc;     // -1 when the cycle is not predicted
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  ev_t  exp_q[$];

  bit   busy_model_en = 1'b0;
  int   busy_left = 0;
  int   lock_mode = 0;   // 0 always high, 1 stuck low, 2 one-cycle glitch
  int   req_s = -1000;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  pll_reconfig_sequencer_if bus_if ();

  pll_reconfig_sequencer #(
    .LOCK_STABLE  (LOCK_STABLE),
    .LOCK_TIMEOUT (LOCK_TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Lock level in cycle t for the current lock mode.
  function automatic bit lock_at(int t);
    case (lock_mode)
      0:       return 1'b1;
      1:       return 1'b0;
      default: return t != req_s + 39;   // WAIT_LOCK entry + 10
    endcase
  endfunction

  // Done cycle: first cycle preceded by LOCK_STABLE high-lock cycles inside
  // WAIT_LOCK, else the timeout LOCK_TIMEOUT cycles after entry.
  function automatic int lock_done_cyc(int e, output int err);
    for (int d = e + LOCK_STABLE; d <= e + LOCK_TIMEOUT; d++) begin
      bit ok = 1'b1;
      for (int t = d - LOCK_STABLE; t < d; t++) if (!lock_at(t)) ok = 1'b0;
      if (ok) begin
        err = 0;
        return d;
      end
    end
    err = 1;
    return e + LOCK_TIMEOUT;
  endfunction

  function automatic void push_ev(ev_kind_t kind, int ct, int cp, int dat, int err, int c);
    ev_t e;
    e.kind = kind; e.ctype = ct; e.cparam = cp; e.data = dat; e.err = err; e.cyc = c;
    exp_q.push_back(e);
  endfunction

  // Megafunction model: busy for 5 cycles after each write or reconfig pulse.
  initial begin
    bus_if.reconfig_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) busy_left = 0;
      else if (busy_model_en && (bus_if.write_param || bus_if.reconfig)) busy_left = 5;
      @(posedge clk);
      #1;
      bus_if.reconfig_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
    end
  end

  // PLL lock driver.
  initial begin
    bus_if.pll_lock = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus_if.pll_lock = lock_at(cyc);
    end
  end

  task automatic expect_event(ev_kind_t kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_event: got %s, expected nothing (cycle %0d)", kind.name(), cyc);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", kind, e.kind);
    if (e.kind != kind) return;
    if (e.cyc >= 0) check({kind.name(), "_cycle"}, cyc, e.cyc);
    case (kind)
      EV_WRITE: begin
        check("counter_type", bus_if.counter_type, e.ctype);
        check("counter_param", bus_if.counter_param, e.cparam);
        check("data_in", bus_if.data_in, e.data);
      end
      EV_DONE: check("done_error", bus_if.error, e.err);
      default: ;
    endcase
  endtask

  // Monitor: compare every DUT pulse against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus_if.write_param) begin
          check("write_while_busy", bus_if.reconfig_busy, 0);
          expect_event(EV_WRITE);
        end
        if (bus_if.reconfig) expect_event(EV_RECONFIG);
        if (bus_if.done)     expect_event(EV_DONE);
      end
    end
  end

  task automatic check_outputs_zero(string tag);
    check({tag, "_busy"}, bus_if.busy, 0);
    check({tag, "_write_param"}, bus_if.write_param, 0);
    check({tag, "_reconfig"}, bus_if.reconfig, 0);
    check({tag, "_done"}, bus_if.done, 0);
    check({tag, "_error"}, bus_if.error, 0);
    check({tag, "_counter_type"}, bus_if.counter_type, 0);
    check({tag, "_counter_param"}, bus_if.counter_param, 0);
    check({tag, "_data_in"}, bus_if.data_in, 0);
  endtask

  // Issue one request; offsets are cycles after the strobe (-1 = unused).
  task automatic do_request(int m, int n, int c0, bit timed,
                            int abort_off, int poke_a, int poke_b);
    int  s, done_c, err;
    bit  aborted;
    int  ct[8];
    int  cp[8];
    int  dat[8];
    aborted = 1'b0;
    @(posedge clk);
    #1;
    bus_if.m = 8'(m); bus_if.n = 8'(n); bus_if.c0 = 8'(c0);
    bus_if.strobe = 1'b1;
    s = cyc;
    req_s = s;
    if (m == 0 || n == 0 || c0 == 0) begin
      done_c = s + 2;
      push_ev(EV_DONE, 0, 0, 0, 1, done_c);
    end else begin
      ct  = '{0, 0, 1, 1, 4, 4, 4, 4};
      cp  = '{7, 4, 7, 4, 0, 1, 4, 5};
      dat = '{n, n == 1, m, m == 1, (c0 + 1) / 2, (c0 == 1) ? 1 : c0 / 2,
              c0 == 1, (c0 > 1) ? c0 % 2 : 0};
      for (int k = 0; k < 8; k++)
        push_ev(EV_WRITE, ct[k], cp[k], dat[k], 0, timed ? s + 2 + 3 * k : -1);
      push_ev(EV_RECONFIG, 0, 0, 0, 0, timed ? s + 26 : -1);
      if (timed) begin
        done_c = lock_done_cyc(s + 29, err);
      end else begin
        done_c = -1;
        err = 0;
      end
      push_ev(EV_DONE, 0, 0, 0, err, done_c);
    end
    for (int i = 0; i < 600 && exp_q.size() > 0 && !aborted; i++) begin
      @(posedge clk);
      #1;
      bus_if.strobe = (cyc == s + poke_a) || (cyc == s + poke_b);
      bus_if.m = 8'($urandom); bus_if.n = 8'($urandom); bus_if.c0 = 8'($urandom);
      if (timed && done_c >= 0) check("busy", bus_if.busy, int'(cyc > s && cyc < done_c));
      if (abort_off >= 0 && cyc == s + abort_off) begin
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_outputs_zero("abort");
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        aborted = 1'b1;
      end
    end
    bus_if.strobe = 1'b0;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL request_timeout: %0d events outstanding, expected 0", exp_q.size());
      exp_q.delete();
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
    end else if (!aborted) begin
      @(posedge clk);
      #1;
      check("idle_after_done", bus_if.busy, 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int m, n, c0;
    reset = 1'b1;
    bus_if.strobe = 1'b0;
    bus_if.m = 8'd0; bus_if.n = 8'd0; bus_if.c0 = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Nominal request with strobes mid-sequence and on the done cycle.
    do_request(40, 4, 7, 1'b1, -1, 10, 45);
    do_request(1, 1, 1, 1'b1, -1, -1, -1);
    do_request(4, 3, 0, 1'b1, -1, -1, -1);
    do_request(0, 5, 5, 1'b1, -1, -1, -1);
    do_request(5, 0, 5, 1'b1, -1, 1, -1);
    do_request(255, 255, 255, 1'b1, -1, -1, -1);
    do_request(2, 7, 2, 1'b1, -1, -1, -1);
    do_request(200, 1, 128, 1'b1, -1, -1, -1);

    // Slow megafunction.
    busy_model_en = 1'b1;
    do_request(40, 4, 7, 1'b0, -1, -1, -1);
    do_request(3, 9, 1, 1'b0, -1, 20, -1);
    busy_model_en = 1'b0;
    repeat (8) @(posedge clk);

    // Lock timeout, then a glitch at stable count 10.
    lock_mode = 1;
    do_request(10, 2, 3, 1'b1, -1, -1, -1);
    lock_mode = 2;
    do_request(12, 3, 5, 1'b1, -1, -1, -1);
    lock_mode = 0;

    // Reset during write k=3, then a full request.
    do_request(40, 4, 7, 1'b1, 11, -1, -1);
    do_request(40, 4, 7, 1'b1, -1, -1, -1);

    // Randomized requests.
    for (int r = 0; r < 25; r++) begin
      busy_model_en = ($urandom_range(0, 1) == 1);
      m  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
      n  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
      c0 = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
      if ($urandom_range(0, 5) == 0) c0 = 1;
      do_request(m, n, c0, !busy_model_en, -1, -1, -1);
      busy_model_en = 1'b0;
      repeat (7) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
